id_ex_pipe_reg: RTL

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

---
 rtl/id_ex_pipe_reg.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register, one falling edge of latency; ID_EX_SKID_EN adds a second (skid) entry.
// Back-pressure: holds everything while out_ready=0; in_ready is combinational without skid, registered with skid.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int CTRL_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] pc_next_in,
   input  logic [DATA_W-1:0] rs_data_in,
   input  logic [DATA_W-1:0] rt_data_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [RA_W-1:0]   rs_addr_in,
   input  logic [RA_W-1:0]   rt_addr_in,
   input  logic [RA_W-1:0]   rd_addr_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] pc_next_out,
   output logic [DATA_W-1:0] rs_data_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [RA_W-1:0]   rs_addr_out,
   output logic [RA_W-1:0]   rt_addr_out,
   output logic [RA_W-1:0]   rd_addr_out,
   output logic [15:0]       stall_cnt
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] pc_next;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [RA_W-1:0]   rs_addr;
      logic [RA_W-1:0]   rt_addr;
      logic [RA_W-1:0]   rd_addr;
   } payload_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, BOTH = 2'd2} state_t;

   state_t   state, state_nxt;
   payload_t in_dat, main_q;
   logic     in_xfer, out_xfer, load_main;

   assign in_dat = {ctrl_in, pc_next_in, rs_data_in, rt_data_in, imm_in,
                    rs_addr_in, rt_addr_in, rd_addr_in};

   assign out_valid = (state != EMPTY);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

`ifdef ID_EX_SKID_EN
   payload_t skid_q;
   logic     load_skid, main_from_skid, in_ready_q;

   assign in_ready = in_ready_q;
`else
   assign in_ready = !out_valid || out_ready;
`endif

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
`ifdef ID_EX_SKID_EN
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
`endif
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nxt = MAIN;
                  load_main = 1'b1;
               end
            end
            MAIN: begin
               if (in_xfer) begin
                  if (out_xfer) begin
                     load_main = 1'b1;
                  end
`ifdef ID_EX_SKID_EN
                  else begin
                     state_nxt = BOTH;
                     load_skid = 1'b1;
                  end
`endif
               end else if (out_xfer) begin
                  state_nxt = EMPTY;
               end
            end
`ifdef ID_EX_SKID_EN
            BOTH: begin
               if (out_xfer) begin
                  state_nxt      = MAIN;
                  main_from_skid = 1'b1;
               end
            end
`endif
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
      end else if (load_main) begin
         main_q <= in_dat;
      end
`ifdef ID_EX_SKID_EN
      else if (main_from_skid) begin
         main_q <= skid_q;
      end
`endif
   end

`ifdef ID_EX_SKID_EN
   // Ready is the registered "skid will be empty" so out_ready never reaches in_ready combinationally.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= (state_nxt != BOTH);
         if (load_skid) begin
            skid_q <= in_dat;
         end
      end
   end
`endif

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Bubbles must never carry live control into EX.
   assign ctrl_out    = out_valid ? main_q.ctrl : '0;
   assign pc_next_out = main_q.pc_next;
   assign rs_data_out = main_q.rs_data;
   assign rt_data_out = main_q.rt_data;
   assign imm_out     = main_q.imm;
   assign rs_addr_out = main_q.rs_addr;
   assign rt_addr_out = main_q.rt_addr;
   assign rd_addr_out = main_q.rd_addr;

endmodule
